// File: rtl/cola_solicitudes_pkg.sv
// Shared definitions for the elevator call queue: floor codes, destino layout,
// SCAN direction codes and FSM state encodings.
package cola_solicitudes_pkg;

   localparam logic [1:0] PISO_MENOS_UNO = 2'b00;
   localparam logic [1:0] PISO_UNO       = 2'b01;
   localparam logic [1:0] PISO_DOS       = 2'b10;
   localparam logic [1:0] PISO_TRES      = 2'b11;

   localparam int NADA_BIT   = 2;
   localparam int NUM_PISOS  = 4;
   localparam int TIMER_W    = 28;

   typedef enum logic [1:0] {
      DIR_NINGUNA = 2'b00,
      DIR_SUBE    = 2'b01,
      DIR_BAJA    = 2'b10
   } dir_t;

   typedef enum logic [1:0] {
      ESPERA    = 2'b00,
      DESPACHO  = 2'b01,
      SIRVIENDO = 2'b10
   } estado_t;

endpackage

// File: rtl/cola_solicitudes_antirrebote.sv
// One call button: two-flop synchroniser, stability debounce and a single-cycle
// pulse on each accepted rising level.
module cola_solicitudes_antirrebote
   import cola_solicitudes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic boton_i,
   output logic pulso_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             estable_q, estable_d;
   logic             previo_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      estable_d = estable_q;
      cnt_d     = '0;
      if (sync2_q != estable_q) begin
         // the level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            estable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         estable_q <= 1'b0;
         previo_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= boton_i;
         sync2_q   <= sync1_q;
         estable_q <= estable_d;
         previo_q  <= estable_q;
         cnt_q     <= cnt_d;
      end
   end

   assign pulso_o = estable_q & ~previo_q;

endmodule

// File: rtl/cola_solicitudes.sv
// Elevator call queue: debounced buttons feed a pending bitmap, a SCAN selector
// picks the next floor and a small FSM issues it to the car controller.
//   state     | meaning
//   ESPERA    | nothing issued, destino = {1,piso}; dispatch when car idle and a call is selectable
//   DESPACHO  | target issued, waiting for ocupado to rise (timeout returns to ESPERA)
//   SIRVIENDO | car moving/serving; retire call when ocupado falls at the target floor
module cola_solicitudes
   import cola_solicitudes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ACK_TIMEOUT     = 200000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PISOS-1:0] boton_i,
   input  logic [1:0]           piso_i,
   input  logic                 ocupado_i,
   output logic [2:0]           destino_o,
   output logic [NUM_PISOS-1:0] pendientes_o,
   output logic                 despachando_o
);

   estado_t              estado_q, estado_d;
   dir_t                 dir_q, dir_d, dir_sel;
   logic [1:0]           objetivo_q, objetivo_d, sel;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [NUM_PISOS-1:0] pend_q, pend_d, pulsos, descarte, borrado;
   logic                 ocupado_q, baja_ocupado, retiro;
   logic                 hay_arriba, hay_abajo, hay_sel;
   logic [1:0]           obj_arriba, obj_abajo;

   for (genvar g = 0; g < NUM_PISOS; g++) begin : g_boton
      cola_solicitudes_antirrebote #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_antirrebote (
         .clk    (clk),
         .rst    (rst),
         .boton_i(boton_i[g]),
         .pulso_o(pulsos[g])
      );
   end

   assign baja_ocupado = ocupado_q & ~ocupado_i;

   // descending scan keeps the nearest floor above, ascending keeps the nearest below
   always_comb begin
      hay_arriba = 1'b0;
      obj_arriba = piso_i;
      hay_abajo  = 1'b0;
      obj_abajo  = piso_i;
      for (int i = NUM_PISOS - 1; i >= 0; i--) begin
         if ((3'(i) > {1'b0, piso_i}) && pend_q[i]) begin
            hay_arriba = 1'b1;
            obj_arriba = 2'(i);
         end
      end
      for (int i = 0; i < NUM_PISOS; i++) begin
         if ((3'(i) < {1'b0, piso_i}) && pend_q[i]) begin
            hay_abajo = 1'b1;
            obj_abajo = 2'(i);
         end
      end
   end

   always_comb begin
      hay_sel = 1'b0;
      sel     = piso_i;
      dir_sel = dir_q;
      if (dir_q == DIR_BAJA) begin
         if (hay_abajo) begin
            hay_sel = 1'b1;
            sel     = obj_abajo;
         end else if (hay_arriba) begin
            hay_sel = 1'b1;
            sel     = obj_arriba;
            dir_sel = DIR_SUBE;
         end
      end else begin
         if (hay_arriba) begin
            hay_sel = 1'b1;
            sel     = obj_arriba;
            dir_sel = DIR_SUBE;
         end else if (hay_abajo) begin
            hay_sel = 1'b1;
            sel     = obj_abajo;
            dir_sel = DIR_BAJA;
         end
      end
   end

   always_comb begin
      estado_d   = estado_q;
      objetivo_d = objetivo_q;
      dir_d      = dir_q;
      timer_d    = timer_q;
      retiro     = 1'b0;
      case (estado_q)
         ESPERA: begin
            timer_d = '0;
            if (!ocupado_i && hay_sel) begin
               objetivo_d = sel;
               dir_d      = dir_sel;
               estado_d   = DESPACHO;
            end
         end
         DESPACHO: begin
            if (ocupado_i) begin
               estado_d = SIRVIENDO;
               timer_d  = '0;
            end else if (timer_q >= TIMER_W'(ACK_TIMEOUT - 1)) begin
               estado_d = ESPERA;
               timer_d  = '0;
            end else if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
         end
         SIRVIENDO: begin
            if (baja_ocupado) begin
               estado_d = ESPERA;
               retiro   = (piso_i == objetivo_q);
            end
         end
         default: estado_d = ESPERA;
      endcase
   end

   // a press at the floor where the idle car already stands is meaningless
   assign descarte = (estado_q == ESPERA && !ocupado_i) ? (4'b0001 << piso_i) : 4'b0000;
   assign borrado  = retiro ? (4'b0001 << objetivo_q) : 4'b0000;
   assign pend_d   = (pend_q | (pulsos & ~descarte)) & ~borrado;

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q   <= ESPERA;
         dir_q      <= DIR_SUBE;
         objetivo_q <= PISO_MENOS_UNO;
         timer_q    <= '0;
         pend_q     <= '0;
         ocupado_q  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         dir_q      <= dir_d;
         objetivo_q <= objetivo_d;
         timer_q    <= timer_d;
         pend_q     <= pend_d;
         ocupado_q  <= ocupado_i;
      end
   end

   always_comb begin
      destino_o           = {1'b0, objetivo_q};
      destino_o[NADA_BIT] = 1'b0;
      if (estado_q == ESPERA) begin
         destino_o           = {1'b0, piso_i};
         destino_o[NADA_BIT] = 1'b1;
      end
   end

   assign pendientes_o  = pend_q;
   assign despachando_o = (estado_q != ESPERA);

endmodule
